// File: rtl/lane_train_pkg.sv
// Shared types and constants for the lane read-training sequencer.
package lane_train_pkg;

    localparam int TAP_W = 8;
    localparam int LEN_W = 9;
    localparam int CNT_W = 16;

    localparam int DEF_DELAY_TAPS    = 128;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_SAMPLE_CYCLES = 16;
    localparam int DEF_MIN_EYE       = 8;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        CLEAR,
        SETTLE,
        SAMPLE,
        EVAL,
        STEP,
        RELOAD,
        SEEK,
        FINISH
    } train_state_e;

endpackage

// File: rtl/eye_run_tracker.sv
// Tracks the current passing run and the longest (earliest on ties) passing window.
module eye_run_tracker
    import lane_train_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAP_W-1:0] tap,
    input  logic             pass,
    input  logic             eval_en,
    input  logic             clr,
    output logic [TAP_W-1:0] best_start,
    output logic [LEN_W-1:0] best_len
);

    logic [TAP_W-1:0] run_start;
    logic [TAP_W-1:0] run_start_nxt;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] run_len_nxt;

    // Candidate run after evaluating the current tap.
    always_comb begin
        run_len_nxt   = '0;
        run_start_nxt = run_start;
        if (pass) begin
            run_len_nxt = run_len + LEN_W'(1);
            if (run_len == '0) begin
                run_start_nxt = tap;
            end
        end
    end

    // Commit the run on each evaluation; a strictly longer run replaces the best window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (clr) begin
            run_start  <= '0;
            run_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
        end else if (eval_en) begin
            run_start <= run_start_nxt;
            run_len   <= run_len_nxt;
            if (run_len_nxt > best_len) begin
                best_start <= run_start_nxt;
                best_len   <= run_len_nxt;
            end
        end
    end

endmodule

// File: rtl/lane_read_eye_sweep_ctrl.sv
// Read-eye sweep: step the RX delay line across all taps, find the widest clean window, park at its center.
module lane_read_eye_sweep_ctrl
    import lane_train_pkg::*;
#(
    parameter int DELAY_TAPS    = DEF_DELAY_TAPS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
    parameter int MIN_EYE       = DEF_MIN_EYE
) (
    input  logic             FAB_CLK,
    input  logic             ARST_N,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             FAIL,
    output logic [TAP_W-1:0] EYE_START,
    output logic [LEN_W-1:0] EYE_WIDTH,
    output logic [TAP_W-1:0] CENTER_TAP,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    input  logic             EYE_MONITOR_EARLY,
    input  logic             EYE_MONITOR_LATE
);

    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(DELAY_TAPS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [LEN_W-1:0] MIN_EYE_L   = LEN_W'(MIN_EYE);

    train_state_e     state;
    train_state_e     state_nxt;
    logic [TAP_W-1:0] tap;
    logic [TAP_W-1:0] tap_nxt;
    logic [TAP_W-1:0] target;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             err;
    logic             start_acc;
    logic [TAP_W-1:0] best_start;
    logic [LEN_W-1:0] best_len;
    logic [LEN_W-1:0] center_sum;
    logic             reload_fail;
    logic [TAP_W-1:0] reload_target;

    eye_run_tracker u_tracker (
        .clk        (FAB_CLK),
        .rst_n      (ARST_N),
        .tap        (tap),
        .pass       (~err),
        .eval_en    (state == EVAL),
        .clr        (start_acc),
        .best_start (best_start),
        .best_len   (best_len)
    );

    assign DELAY_LINE_DIRECTION = 1'b1;

    // Park target derived from the best window; a failed eye parks at tap 0.
    always_comb begin
        center_sum    = {1'b0, best_start} + (best_len >> 1);
        reload_fail   = (best_len < MIN_EYE_L);
        reload_target = reload_fail ? '0 : center_sum[TAP_W-1:0];
    end

    // Next-state, tap and phase-counter logic.
    always_comb begin
        state_nxt = state;
        tap_nxt   = tap;
        cnt_nxt   = cnt;
        start_acc = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    state_nxt = LOAD;
                    start_acc = 1'b1;
                    tap_nxt   = '0;
                end
            end
            LOAD: begin
                tap_nxt   = '0;
                state_nxt = CLEAR;
            end
            CLEAR: begin
                cnt_nxt   = '0;
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = SAMPLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = EVAL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            EVAL: begin
                if ((tap == LAST_TAP) || DELAY_LINE_OUT_OF_RANGE) begin
                    state_nxt = RELOAD;
                end else begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                tap_nxt   = tap + TAP_W'(1);
                state_nxt = CLEAR;
            end
            RELOAD: begin
                tap_nxt   = '0;
                state_nxt = (reload_target == '0) ? FINISH : SEEK;
            end
            SEEK: begin
                tap_nxt = tap + TAP_W'(1);
                if ((tap + TAP_W'(1)) == target) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, tap and counter registers.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state <= IDLE;
            tap   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            tap   <= tap_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sticky sampling error: cleared on SAMPLE entry, ORs in flags every sample cycle.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            err <= 1'b0;
        end else if ((state_nxt == SAMPLE) && (state != SAMPLE)) begin
            err <= 1'b0;
        end else if (state == SAMPLE) begin
            err <= err | EYE_MONITOR_EARLY | EYE_MONITOR_LATE;
        end
    end

    // Results: captured at RELOAD, center captured on entry to FINISH.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            FAIL       <= 1'b0;
            EYE_START  <= '0;
            EYE_WIDTH  <= '0;
            CENTER_TAP <= '0;
            target     <= '0;
        end else begin
            if (start_acc) begin
                FAIL <= 1'b0;
            end else if (state == RELOAD) begin
                FAIL      <= reload_fail;
                EYE_START <= best_start;
                EYE_WIDTH <= best_len;
                target    <= reload_target;
            end
            if ((state_nxt == FINISH) && (state != FINISH)) begin
                CENTER_TAP <= tap_nxt;
            end
        end
    end

    // Registered control pulses, aligned with the state that owns them.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            BUSY                    <= 1'b0;
            DONE                    <= 1'b0;
            DELAY_LINE_LOAD         <= 1'b0;
            DELAY_LINE_MOVE         <= 1'b0;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
        end else begin
            BUSY                    <= (state_nxt != IDLE);
            DONE                    <= (state_nxt == FINISH);
            DELAY_LINE_LOAD         <= (state_nxt == LOAD) || (state_nxt == RELOAD);
            DELAY_LINE_MOVE         <= (state_nxt == STEP) || (state_nxt == SEEK);
            EYE_MONITOR_CLEAR_FLAGS <= (state_nxt == CLEAR);
        end
    end

endmodule

// File: tb/tb_lane_read_eye_sweep_ctrl.sv
// Bench: IOD delay-line/eye-monitor model plus a window-scanning reference for training results.
module tb_lane_read_eye_sweep_ctrl;

    localparam int DELAY_TAPS = 128;
    localparam int SETTLE     = 4;
    localparam int SAMPLE     = 16;
    localparam int MIN_EYE    = 8;
    localparam int MAX_WAIT   = 6000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       early = 1'b0;
    logic       late = 1'b0;
    logic       oor = 1'b0;
    logic       busy, done, fail, load, move, dir, clr_flags;
    logic [7:0] eye_start, center_tap;
    logic [8:0] eye_width;

    logic [255:0] pass_mask;
    int           oor_tap;
    int           iod_tap;
    int           load_cnt, move_cnt, moves_since_load, dir_err, overlap_err;
    int           total, bad;

    always #5 clk = ~clk;

    lane_read_eye_sweep_ctrl #(
        .DELAY_TAPS    (DELAY_TAPS),
        .SETTLE_CYCLES (SETTLE),
        .SAMPLE_CYCLES (SAMPLE),
        .MIN_EYE       (MIN_EYE)
    ) dut (
        .FAB_CLK                 (clk),
        .ARST_N                  (rst_n),
        .START                   (start),
        .BUSY                    (busy),
        .DONE                    (done),
        .FAIL                    (fail),
        .EYE_START               (eye_start),
        .EYE_WIDTH               (eye_width),
        .CENTER_TAP              (center_tap),
        .DELAY_LINE_LOAD         (load),
        .DELAY_LINE_MOVE         (move),
        .DELAY_LINE_DIRECTION    (dir),
        .DELAY_LINE_OUT_OF_RANGE (oor),
        .EYE_MONITOR_CLEAR_FLAGS (clr_flags),
        .EYE_MONITOR_EARLY       (early),
        .EYE_MONITOR_LATE        (late)
    );

    // IOD model: flags reflect the tap the delay line sits at this cycle, then pulses move the tap.
    initial begin : iod_model
        int r;
        iod_tap = 0;
        forever begin
            @(negedge clk);
            if (iod_tap < 256 && pass_mask[iod_tap]) begin
                early = 1'b0;
                late  = 1'b0;
            end else begin
                r     = $urandom_range(1, 3);
                early = r[0];
                late  = r[1];
            end
            oor = (iod_tap >= oor_tap);
            if ((int'(load) + int'(move) + int'(clr_flags)) > 1) overlap_err++;
            if (load) begin
                load_cnt++;
                moves_since_load = 0;
                iod_tap = 0;
            end
            if (move) begin
                move_cnt++;
                moves_since_load++;
                iod_tap++;
                if (dir !== 1'b1) dir_err++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic setMask(input int lo, input int hi);
        for (int t = lo; t <= hi; t++) pass_mask[t] = 1'b1;
    endtask

    // Reference: scan the swept taps for maximal passing runs and keep the first longest one.
    task automatic computeExpected(output int e_start, output int e_width, output int e_center,
                                   output int e_fail, output int e_last);
        int w;
        e_last = DELAY_TAPS - 1;
        if (oor_tap < e_last) e_last = oor_tap;
        e_start = 0;
        e_width = 0;
        for (int t = 0; t <= e_last; t++) begin
            if (pass_mask[t] && (t == 0 || !pass_mask[t-1])) begin
                w = 0;
                while (t + w <= e_last && pass_mask[t+w]) w++;
                if (w > e_width) begin
                    e_width = w;
                    e_start = t;
                end
            end
        end
        e_fail   = (e_width < MIN_EYE) ? 1 : 0;
        e_center = e_fail ? 0 : e_start + e_width / 2;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_fail"}, 32'(fail), 0);
        checkOutput({tag, "_load"}, 32'(load), 0);
        checkOutput({tag, "_move"}, 32'(move), 0);
        checkOutput({tag, "_clear"}, 32'(clr_flags), 0);
        checkOutput({tag, "_eye_start"}, 32'(eye_start), 0);
        checkOutput({tag, "_eye_width"}, 32'(eye_width), 0);
        checkOutput({tag, "_center"}, 32'(center_tap), 0);
        checkOutput({tag, "_dir"}, 32'(dir), 1);
    endtask

    // One full training run; optional extra START at cycle mid_start_at, and a START coincident with DONE.
    task automatic applyStimulus(input string tag, input int mid_start_at);
        int e_start, e_width, e_center, e_fail, e_last;
        int cyc;
        int got_done;
        logic [31:0] o_start, o_width, o_center, o_fail;
        int o_loads, o_moves, o_seek;
        computeExpected(e_start, e_width, e_center, e_fail, e_last);
        load_cnt = 0; move_cnt = 0; moves_since_load = 0; dir_err = 0; overlap_err = 0;
        o_start = '0; o_width = '0; o_center = '0; o_fail = '0;
        o_loads = 0; o_moves = 0; o_seek = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_busy_on_start"}, 32'(busy), 1);
        checkOutput({tag, "_load_after_start"}, 32'(load), 1);
        cyc = 0;
        got_done = 0;
        while (cyc < MAX_WAIT && got_done == 0) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                got_done = 1;
                o_start  = 32'(eye_start);
                o_width  = 32'(eye_width);
                o_center = 32'(center_tap);
                o_fail   = 32'(fail);
                o_loads  = load_cnt;
                o_moves  = move_cnt;
                o_seek   = moves_since_load;
            end
            start = (got_done == 1 || cyc == mid_start_at) ? 1'b1 : 1'b0;
        end
        checkOutput({tag, "_done_seen"}, got_done, 1);
        checkOutput({tag, "_eye_start"}, o_start, e_start);
        checkOutput({tag, "_eye_width"}, o_width, e_width);
        checkOutput({tag, "_center"}, o_center, e_center);
        checkOutput({tag, "_fail"}, o_fail, e_fail);
        checkOutput({tag, "_loads"}, o_loads, 2);
        checkOutput({tag, "_seek_moves"}, o_seek, e_center);
        checkOutput({tag, "_sweep_moves"}, o_moves - o_seek, e_last);
        checkOutput({tag, "_dir_errors"}, dir_err, 0);
        checkOutput({tag, "_pulse_overlap"}, overlap_err, 0);
        @(negedge clk);
        start = 1'b0;
        checkOutput({tag, "_idle_after_done"}, 32'(busy), 0);
        checkOutput({tag, "_done_one_cycle"}, 32'(done), 0);
        $display("[TB] %s: start=%0d width=%0d center=%0d fail=%0d", tag, e_start, e_width, e_center, e_fail);
    endtask

    initial begin
        int n, s, l;
        total = 0;
        bad = 0;
        pass_mask = '0;
        oor_tap = 1000;

        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkReset("reset_init");
        rst_n = 1'b1;

        pass_mask = '0; setMask(10, 29); oor_tap = 1000;
        applyStimulus("mid_window", 0);

        pass_mask = '1; oor_tap = 1000;
        applyStimulus("no_flags", 0);

        pass_mask = '0; setMask(5, 14); setMask(40, 49); oor_tap = 1000;
        applyStimulus("two_windows", 0);

        pass_mask = '0; setMask(30, 34); oor_tap = 1000;
        applyStimulus("narrow_eye", 0);

        pass_mask = '0; setMask(40, 60); oor_tap = 50;
        applyStimulus("out_of_range", 0);

        pass_mask = '0; setMask(10, 29); oor_tap = 1000;
        applyStimulus("start_while_busy", 500);

        // Drop reset in the middle of tap 4's sample window (cycle 105 after START).
        pass_mask = '0; setMask(20, 60); oor_tap = 1000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (104) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkReset("reset_mid_sample");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after_reset", 0);

        for (int k = 0; k < 3; k++) begin
            pass_mask = '0;
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                s = $urandom_range(0, 120);
                l = $urandom_range(1, 40);
                setMask(s, (s + l - 1 > 255) ? 255 : s + l - 1);
            end
            oor_tap = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 127) : 1000;
            applyStimulus($sformatf("random%0d", k), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
